// File: rtl/rv32_dmem_responder.sv
// RV32 data-memory responder: accepts one load/store at a time, answers
// LATENCY cycles later. Byte-lane writes and sign/zero-extended loads.
// Faulting requests return rsp_err=1 with no array write.
package rv32_dmem_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        read_enable;
    logic        write_enable;
  } rv32_mem_packet_t;

  typedef struct packed {
    logic [2:0] load_type;
    logic [1:0] store_type;
  } rv32_ex_control_packet_t;
endpackage

module rv32_dmem_responder
  import rv32_dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  rv32_mem_packet_t        req_mem,
  input  rv32_ex_control_packet_t req_ctrl,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [31:0]             rsp_data,
  output logic                    rsp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]              state;
  logic [2:0]              cnt;
  rv32_mem_packet_t        mem_p0;
  rv32_ex_control_packet_t ctrl_p0;
  logic [31:0]             rsp_data_p1;
  logic                    rsp_err_p1;
  logic [31:0]             ram [DEPTH_WORDS];

  rv32_mem_packet_t        src_mem;
  rv32_ex_control_packet_t src_ctrl;
  logic                    enter_resp;
  logic                    acc_err;
  logic                    is_store;
  logic [AW-1:0]           widx;
  logic [31:0]             rd_word;
  logic                    ram_we;
  logic [3:0]              ram_be;
  logic [31:0]             ram_wdata;

  // Fault detection: enable combination, illegal type, misalignment, range.
  function automatic logic access_fault(input rv32_mem_packet_t m,
                                        input rv32_ex_control_packet_t c);
    logic f;
    f = 1'b0;
    if (m.read_enable == m.write_enable) begin
      f = 1'b1;
    end else if ({2'b00, m.addr[31:2]} >= 32'(DEPTH_WORDS)) begin
      f = 1'b1;
    end else if (m.read_enable) begin
      case (c.load_type)
        3'b000, 3'b100: f = 1'b0;
        3'b001, 3'b101: f = m.addr[0];
        3'b010:         f = |m.addr[1:0];
        default:        f = 1'b1;
      endcase
    end else begin
      case (c.store_type)
        2'b00:   f = 1'b0;
        2'b01:   f = m.addr[0];
        2'b10:   f = |m.addr[1:0];
        default: f = 1'b1;
      endcase
    end
    return f;
  endfunction

  // Lane selection plus sign/zero extension for the load types.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [2:0]  lt);
    logic [31:0]        shifted;
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic [31:0]        r;
    shifted = word >> {lane, 3'b000};
    b_s     = shifted[7:0];
    h_s     = shifted[15:0];
    case (lt)
      3'b000:  r = 32'(b_s);
      3'b001:  r = 32'(h_s);
      3'b100:  r = {24'd0, shifted[7:0]};
      3'b101:  r = {16'd0, shifted[15:0]};
      default: r = word;
    endcase
    return r;
  endfunction

  assign req_ready = (state == S_IDLE) && !rst;
  assign rsp_valid = (state == S_RESP);
  assign rsp_data  = rsp_data_p1;
  assign rsp_err   = rsp_err_p1;

  // With LATENCY=1 the access happens on the accepting edge, before capture.
  assign src_mem    = (state == S_IDLE) ? req_mem  : mem_p0;
  assign src_ctrl   = (state == S_IDLE) ? req_ctrl : ctrl_p0;
  assign enter_resp = !rst &&
                      (((state == S_IDLE) && req_valid && (LATENCY == 1)) ||
                       ((state == S_WAIT) && (cnt == 3'd1)));
  assign acc_err    = access_fault(src_mem, src_ctrl);
  assign is_store   = src_mem.write_enable && !src_mem.read_enable;
  assign widx       = src_mem.addr[AW+1:2];
  assign rd_word    = ram[widx];
  assign ram_we     = enter_resp && is_store && !acc_err;

  // Byte enables and lane-replicated write data for the store type.
  always_comb begin
    ram_be    = 4'b0000;
    ram_wdata = src_mem.data;
    case (src_ctrl.store_type)
      2'b00: begin
        ram_be    = 4'b0001 << src_mem.addr[1:0];
        ram_wdata = {4{src_mem.data[7:0]}};
      end
      2'b01: begin
        ram_be    = src_mem.addr[1] ? 4'b1100 : 4'b0011;
        ram_wdata = {2{src_mem.data[15:0]}};
      end
      default: ram_be = 4'b1111;
    endcase
  end

  // Control FSM, request capture and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= 3'd0;
      mem_p0      <= '0;
      ctrl_p0     <= '0;
      rsp_data_p1 <= 32'd0;
      rsp_err_p1  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          mem_p0  <= req_mem;
          ctrl_p0 <= req_ctrl;
          cnt     <= 3'(LATENCY - 1);
          state   <= (LATENCY == 1) ? S_RESP : S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) state <= S_RESP;
        end
        S_RESP: if (rsp_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      // ---- response stage: array access resolves here ----
      if (enter_resp) begin
        rsp_err_p1  <= acc_err;
        rsp_data_p1 <= (acc_err || is_store) ? 32'd0
                       : load_extend(rd_word, src_mem.addr[1:0], src_ctrl.load_type);
      end
    end
  end

  // Data array: byte-lane writes, contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_be[b]) ram[widx][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_rv32_dmem_responder.sv
// Directed bench for rv32_dmem_responder with LATENCY=2, DEPTH_WORDS=1024.
module tb_rv32_dmem_responder;
  import rv32_dmem_pkg::*;

  localparam int DW  = 1024;
  localparam int LAT = 2;
  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
  localparam logic [1:0] SB = 2'b00, SH = 2'b01, SW = 2'b10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic req_ready;
  rv32_mem_packet_t        req_mem = '0;
  rv32_ex_control_packet_t req_ctrl = '0;
  logic rsp_valid;
  logic rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic rsp_err;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int cyc      = 0;
  int acc_cyc  = 0;

  rv32_dmem_responder #(.DEPTH_WORDS(DW), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_mem(req_mem), .req_ctrl(req_ctrl),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  // Drive one request, wait for acceptance and response; lat = -1 if none.
  task automatic do_req(input logic re, input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [2:0] lt, input logic [1:0] st,
                        output logic [31:0] d, output logic e, output int lat);
    int w;
    d = 32'hx; e = 1'bx; lat = -1;
    @(posedge clk); #1;
    req_mem   = '{addr: a, data: wd, read_enable: re, write_enable: we};
    req_ctrl  = '{load_type: lt, store_type: st};
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    @(posedge clk); #1;
    acc_cyc   = cyc;
    req_valid = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (rsp_valid) begin lat = n; d = rsp_data; e = rsp_err; break; end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_cnt++; if (req_ready !== 1'b0) $display("FAIL rst_req_ready got %b want 0", req_ready); else pass_cnt++;
    chk_cnt++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid got %b want 0", rsp_valid); else pass_cnt++;
    chk_cnt++; if (rsp_data !== 32'd0) $display("FAIL rst_rsp_data got %h want 0", rsp_data); else pass_cnt++;
    chk_cnt++; if (rsp_err !== 1'b0) $display("FAIL rst_rsp_err got %b want 0", rsp_err); else pass_cnt++;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_cnt++; if (req_ready !== 1'b1) $display("FAIL post_rst_ready got %b want 1", req_ready); else pass_cnt++;
  endtask

  task automatic test_sw_lw();
    logic [31:0] d; logic e; int l;
    do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, LB, SW, d, e, l);
    chk_cnt++; if (d !== 32'd0 || e !== 1'b0) $display("FAIL sw10 got %h/%b want 00000000/0", d, e); else pass_cnt++;
    chk_cnt++; if (l !== LAT) $display("FAIL sw10_latency got %0d want %0d", l, LAT); else pass_cnt++;
    do_req(1'b1, 1'b0, 32'h10, 32'h0, LW, SB, d, e, l);
    chk_cnt++; if (d !== 32'hDEADBEEF || e !== 1'b0) $display("FAIL lw10 got %h/%b want deadbeef/0", d, e); else pass_cnt++;
    chk_cnt++; if (l !== LAT) $display("FAIL lw10_latency got %0d want %0d", l, LAT); else pass_cnt++;
  endtask

  task automatic test_subword();
    logic [31:0] d; logic e; int l;
    do_req(1'b0, 1'b1, 32'h11, 32'h80, LB, SB, d, e, l);
    chk_cnt++; if (d !== 32'd0 || e !== 1'b0) $display("FAIL sb11 got %h/%b want 00000000/0", d, e); else pass_cnt++;
    do_req(1'b1, 1'b0, 32'h11, 32'h0, LB, SB, d, e, l);
    chk_cnt++; if (d !== 32'hFFFFFF80) $display("FAIL lb11 got %h want ffffff80", d); else pass_cnt++;
    do_req(1'b1, 1'b0, 32'h11, 32'h0, LBU, SB, d, e, l);
    chk_cnt++; if (d !== 32'h00000080) $display("FAIL lbu11 got %h want 00000080", d); else pass_cnt++;
    do_req(1'b1, 1'b0, 32'h10, 32'h0, LW, SB, d, e, l);
    chk_cnt++; if (d !== 32'hDEAD80EF) $display("FAIL lw10_after_sb got %h want dead80ef", d); else pass_cnt++;
    do_req(1'b1, 1'b0, 32'h12, 32'h0, LH, SB, d, e, l);
    chk_cnt++; if (d !== 32'hFFFFDEAD) $display("FAIL lh12 got %h want ffffdead", d); else pass_cnt++;
    do_req(1'b1, 1'b0, 32'h10, 32'h0, LHU, SB, d, e, l);
    chk_cnt++; if (d !== 32'h000080EF) $display("FAIL lhu10 got %h want 000080ef", d); else pass_cnt++;
    do_req(1'b0, 1'b1, 32'h30, 32'h11223344, LB, SW, d, e, l);
    do_req(1'b0, 1'b1, 32'h32, 32'h5555ABCD, LB, SH, d, e, l);
    do_req(1'b1, 1'b0, 32'h30, 32'h0, LW, SB, d, e, l);
    chk_cnt++; if (d !== 32'hABCD3344) $display("FAIL sh32_merge got %h want abcd3344", d); else pass_cnt++;
  endtask

  task automatic test_errors();
    logic [31:0] d; logic e; int l;
    do_req(1'b1, 1'b0, 32'h13, 32'h0, LH, SB, d, e, l);
    chk_cnt++; if (d !== 32'd0 || e !== 1'b1) $display("FAIL lh13_err got %h/%b want 00000000/1", d, e); else pass_cnt++;
    do_req(1'b0, 1'b1, 32'h12, 32'hFFFFFFFF, LB, SW, d, e, l);
    chk_cnt++; if (d !== 32'd0 || e !== 1'b1) $display("FAIL sw12_err got %h/%b want 00000000/1", d, e); else pass_cnt++;
    do_req(1'b1, 1'b0, DW * 4, 32'h0, LW, SB, d, e, l);
    chk_cnt++; if (d !== 32'd0 || e !== 1'b1) $display("FAIL lw_range_err got %h/%b want 00000000/1", d, e); else pass_cnt++;
    do_req(1'b1, 1'b0, 32'h10, 32'h0, LW, SB, d, e, l);
    chk_cnt++; if (d !== 32'hDEAD80EF || e !== 1'b0) $display("FAIL lw10_after_err got %h/%b want dead80ef/0", d, e); else pass_cnt++;
  endtask

  task automatic test_illegal();
    logic [31:0] d; logic e; int l;
    do_req(1'b1, 1'b1, 32'h10, 32'hFFFFFFFF, LW, SW, d, e, l);
    chk_cnt++; if (d !== 32'd0 || e !== 1'b1) $display("FAIL both_en_err got %h/%b want 00000000/1", d, e); else pass_cnt++;
    do_req(1'b0, 1'b0, 32'h10, 32'h0, LW, SW, d, e, l);
    chk_cnt++; if (e !== 1'b1) $display("FAIL no_en_err got %b want 1", e); else pass_cnt++;
    do_req(1'b1, 1'b0, 32'h10, 32'h0, 3'b011, SB, d, e, l);
    chk_cnt++; if (d !== 32'd0 || e !== 1'b1) $display("FAIL lt011_err got %h/%b want 00000000/1", d, e); else pass_cnt++;
    do_req(1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, LB, 2'b11, d, e, l);
    chk_cnt++; if (d !== 32'd0 || e !== 1'b1) $display("FAIL st11_err got %h/%b want 00000000/1", d, e); else pass_cnt++;
    do_req(1'b1, 1'b0, 32'h10, 32'h0, LW, SB, d, e, l);
    chk_cnt++; if (d !== 32'hDEAD80EF) $display("FAIL lw10_after_illegal got %h want dead80ef", d); else pass_cnt++;
  endtask

  task automatic test_hold();
    int w; int seen;
    @(posedge clk); #1;
    req_mem   = '{addr: 32'h10, data: 32'h0, read_enable: 1'b1, write_enable: 1'b0};
    req_ctrl  = '{load_type: LW, store_type: SB};
    req_valid = 1'b1;
    rsp_ready = 1'b0;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    @(posedge clk); #1 req_valid = 1'b0;
    seen = 0;
    for (int n = 0; n < 20 && seen == 0; n++) begin @(negedge clk); if (rsp_valid) seen = 1; end
    chk_cnt++; if (seen !== 1) $display("FAIL hold_rsp_seen got %0d want 1", seen); else pass_cnt++;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk_cnt++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'hDEAD80EF || rsp_err !== 1'b0 || req_ready !== 1'b0)
        $display("FAIL hold_stable_%0d got v=%b d=%h e=%b rdy=%b want 1/dead80ef/0/0",
                 k, rsp_valid, rsp_data, rsp_err, req_ready);
      else pass_cnt++;
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    chk_cnt++; if (rsp_valid !== 1'b1) $display("FAIL hold_release_valid got %b want 1", rsp_valid); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) $display("FAIL hold_idle got rdy=%b v=%b want 1/0", req_ready, rsp_valid); else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    logic [31:0] d; logic e; int l; int w; int stray;
    do_req(1'b0, 1'b1, 32'h20, 32'hCAFEF00D, LB, SW, d, e, l);
    @(posedge clk); #1;
    req_mem   = '{addr: 32'h20, data: 32'h12345678, read_enable: 1'b0, write_enable: 1'b1};
    req_ctrl  = '{load_type: LB, store_type: SW};
    req_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    stray = 0;
    for (int k = 0; k < 6; k++) begin @(negedge clk); if (rsp_valid) stray++; end
    chk_cnt++; if (stray !== 0) $display("FAIL abort_no_rsp got %0d responses want 0", stray); else pass_cnt++;
    do_req(1'b1, 1'b0, 32'h20, 32'h0, LW, SB, d, e, l);
    chk_cnt++; if (d !== 32'hCAFEF00D || e !== 1'b0) $display("FAIL abort_lw20 got %h/%b want cafef00d/0", d, e); else pass_cnt++;
    do_req(1'b1, 1'b0, 32'h10, 32'h0, LW, SB, d, e, l);
    chk_cnt++; if (d !== 32'hDEAD80EF) $display("FAIL reset_keeps_array got %h want dead80ef", d); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic e; int l; int a1;
    do_req(1'b1, 1'b0, 32'h30, 32'h0, LW, SB, d, e, l);
    a1 = acc_cyc;
    do_req(1'b1, 1'b0, 32'h31, 32'h0, LBU, SB, d, e, l);
    chk_cnt++; if (acc_cyc - a1 !== LAT + 1) $display("FAIL b2b_spacing got %0d want %0d", acc_cyc - a1, LAT + 1); else pass_cnt++;
    chk_cnt++; if (d !== 32'h00000033) $display("FAIL b2b_lbu31 got %h want 00000033", d); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_sw_lw();
    test_subword();
    test_errors();
    test_illegal();
    test_hold();
    test_reset_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
